// File: rtl/axis_fifo_pkg.sv
// Shared types for the store-and-forward AXI-Stream packet FIFO.
package axis_fifo_pkg;

  typedef enum logic {
    WRITE = 1'b0,
    DROP  = 1'b1
  } wstate_t;

endpackage

// File: rtl/axis_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module axis_sdp_ram #(
  parameter int AW = 9,
  parameter int W  = 38
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axis_packet_fifo.sv
// Store-and-forward AXI-Stream packet FIFO: a packet becomes visible downstream only
// once its tlast beat is stored; packets that do not fit are discarded whole.
module axis_packet_fifo
  import axis_fifo_pkg::*;
#(
  parameter  int DSIZE = 32,
  parameter  int USIZE = 1,
  parameter  int KSIZE = (DSIZE < 8) ? 1 : DSIZE / 8,
  parameter  int DEPTH = 512,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [DSIZE-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic [USIZE-1:0] s_axis_tuser,
  input  logic             s_axis_tlast,
  input  logic [KSIZE-1:0] s_axis_tkeep,
  output logic [DSIZE-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [USIZE-1:0] m_axis_tuser,
  output logic             m_axis_tlast,
  output logic [KSIZE-1:0] m_axis_tkeep,
  output logic [AW:0]      pkt_count,
  output logic             drop_pulse
);

  localparam int         W       = DSIZE + USIZE + KSIZE + 1;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  wstate_t     state, state_nx;
  logic [AW:0] wr_ptr, cm_ptr, rd_ptr, used, free, cnt;
  logic        s_ready_r, drop_r, accept, wr_en, commit, rewind;
  logic        rd_en, ram_vld, m_valid_r, out_ready, advance, pop_last;
  logic [W-1:0] ram_dout, out_q;

  assign accept    = s_axis_tvalid && s_ready_r;
  assign used      = wr_ptr - rd_ptr;
  assign free      = (AW+1)'(DEPTH) - used;

  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    commit   = 1'b0;
    rewind   = 1'b0;
    case (state)
      WRITE: if (accept) begin
        if (free != '0) begin
          wr_en  = 1'b1;
          commit = s_axis_tlast;
        end else if (s_axis_tlast) begin
          rewind = 1'b1;
        end else begin
          state_nx = DROP;
        end
      end
      DROP: if (accept && s_axis_tlast) begin
        rewind   = 1'b1;
        state_nx = WRITE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) state <= WRITE;
    else        state <= state_nx;
  end

  // Two-stage read pipeline: RAM output register feeds the master output register.
  assign out_ready = !m_valid_r || m_axis_tready;
  assign advance   = ram_vld && out_ready;
  assign rd_en     = (rd_ptr != cm_ptr) && (!ram_vld || out_ready);
  assign pop_last  = m_valid_r && m_axis_tready && out_q[W-1];

  axis_sdp_ram #(.AW(AW), .W(W)) u_ram (
    .clk   (aclk),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ({s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata}),
    .re    (rd_en),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (ram_dout)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr    <= '0;
      cm_ptr    <= '0;
      rd_ptr    <= '0;
      s_ready_r <= 1'b0;
      drop_r    <= 1'b0;
      ram_vld   <= 1'b0;
      m_valid_r <= 1'b0;
      cnt       <= '0;
    end else begin
      s_ready_r <= 1'b1;
      drop_r    <= rewind;
      if (rewind)     wr_ptr <= cm_ptr;
      else if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (commit) cm_ptr <= wr_ptr + PTR_ONE;
      if (rd_en)  rd_ptr <= rd_ptr + PTR_ONE;

      if (rd_en)        ram_vld <= 1'b1;
      else if (advance) ram_vld <= 1'b0;

      if (advance) begin
        m_valid_r <= 1'b1;
        out_q     <= ram_dout;
      end else if (m_valid_r && m_axis_tready) begin
        m_valid_r <= 1'b0;
      end

      case ({commit, pop_last})
        2'b10:   cnt <= cnt + PTR_ONE;
        2'b01:   cnt <= cnt - PTR_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  assign s_axis_tready = s_ready_r;
  assign m_axis_tvalid = m_valid_r;
  assign {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = out_q;
  assign pkt_count     = cnt;
  assign drop_pulse    = drop_r;

endmodule
